// File: rtl/theta_tracker.sv
// Rotation-gesture tracker: quantises sign-magnitude vectors into 16 CCW-ordered sectors
// and emits a CW/CCW event after RUN_LEN consecutive same-direction sector steps.
module theta_tracker #(
    parameter int unsigned BITS    = 8,
    parameter int unsigned RUN_LEN = 4,
    parameter int unsigned MIN_MAG = 8,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_clear,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic            i_xSign,
    input  logic            i_ySign,
    input  logic [BITS-1:0] i_x,
    input  logic [BITS-1:0] i_y,
    output logic [3:0]      o_theta,
    output logic            o_theta_valid,
    output logic            o_event_valid,
    output logic            o_event_dir,
    output logic [3:0]      o_run
);

    localparam int unsigned W      = BITS + 3;
    localparam logic [15:0] ToLast = 16'(TIMEOUT - 1);
    localparam logic [3:0]  RunLen = 4'(RUN_LEN);

    typedef enum logic [0:0] {StIdle, StCalc} state_e;

    state_e          state_q, state_d;
    logic            xs_q, xs_d, ys_q, ys_d;
    logic [BITS-1:0] xm_q, xm_d, ym_q, ym_d;
    logic [3:0]      prev_theta_q, prev_theta_d;
    logic            prev_valid_q, prev_valid_d;
    logic [3:0]      run_q, run_d;
    logic            dir_q, dir_d;
    logic [15:0]     to_cnt_q, to_cnt_d;
    logic [3:0]      theta_q, theta_d;
    logic            theta_valid_q, theta_valid_d;
    logic            event_valid_q, event_valid_d;
    logic            event_dir_q, event_dir_d;

    logic            swap, dead, ccw, step, same_dir;
    logic [W-1:0]    px, py;
    logic [1:0]      fine;
    logic [3:0]      theta, diff, run_step;
    logic [BITS-1:0] mag_max;

    assign o_ready = (state_q == StIdle) && !i_clear;

    // Sector quantiser and step classification on the latched vector.
    always_comb begin
        swap     = xs_q ^ ys_q;
        px       = swap ? W'(ym_q) : W'(xm_q);
        py       = swap ? W'(xm_q) : W'(ym_q);
        fine     = 2'((py << 1) > px * W'(5)) + 2'(py > px) + 2'(py * W'(5) > (px << 1));
        theta    = {ys_q, swap, fine};
        mag_max  = (xm_q > ym_q) ? xm_q : ym_q;
        dead     = 32'(mag_max) < MIN_MAG;
        // 4-bit wrap of the difference gives the signed modulo-16 step for free.
        diff     = theta - prev_theta_q;
        ccw      = (diff >= 4'd1) && (diff <= 4'd3);
        step     = ccw || (diff >= 4'd13);
        same_dir = (run_q == 4'd0) || (dir_q == ccw);
        run_step = same_dir ? run_q + 4'd1 : 4'd1;
    end

    always_comb begin
        state_d       = state_q;
        xs_d          = xs_q;
        ys_d          = ys_q;
        xm_d          = xm_q;
        ym_d          = ym_q;
        prev_theta_d  = prev_theta_q;
        prev_valid_d  = prev_valid_q;
        run_d         = run_q;
        dir_d         = dir_q;
        to_cnt_d      = to_cnt_q;
        theta_d       = theta_q;
        theta_valid_d = 1'b0;
        event_valid_d = 1'b0;
        event_dir_d   = event_dir_q;

        if (i_clear) begin
            state_d      = StIdle;
            prev_valid_d = 1'b0;
            run_d        = '0;
            dir_d        = 1'b0;
            to_cnt_d     = '0;
        end else begin
            // Timeout first; a step in the CALC branch below overrides it.
            if (run_q == 4'd0) begin
                to_cnt_d = '0;
            end else if (to_cnt_q == ToLast) begin
                run_d    = '0;
                to_cnt_d = '0;
            end else begin
                to_cnt_d = to_cnt_q + 16'd1;
            end

            unique case (state_q)
                StIdle: begin
                    if (i_valid) begin
                        xs_d    = i_xSign;
                        ys_d    = i_ySign;
                        xm_d    = i_x;
                        ym_d    = i_y;
                        state_d = StCalc;
                    end
                end
                StCalc: begin
                    state_d = StIdle;
                    if (!dead) begin
                        theta_d       = theta;
                        theta_valid_d = 1'b1;
                        prev_theta_d  = theta;
                        if (!prev_valid_q) begin
                            prev_valid_d = 1'b1;
                            run_d        = '0;
                        end else if (step) begin
                            dir_d    = ccw;
                            to_cnt_d = '0;
                            if (run_step == RunLen) begin
                                run_d         = '0;
                                event_valid_d = 1'b1;
                                event_dir_d   = ccw;
                            end else begin
                                run_d = run_step;
                            end
                        end else if (diff != 4'd0) begin
                            run_d    = '0;
                            to_cnt_d = '0;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q       <= StIdle;
            xs_q          <= 1'b0;
            ys_q          <= 1'b0;
            xm_q          <= '0;
            ym_q          <= '0;
            prev_theta_q  <= '0;
            prev_valid_q  <= 1'b0;
            run_q         <= '0;
            dir_q         <= 1'b0;
            to_cnt_q      <= '0;
            theta_q       <= '0;
            theta_valid_q <= 1'b0;
            event_valid_q <= 1'b0;
            event_dir_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            xs_q          <= xs_d;
            ys_q          <= ys_d;
            xm_q          <= xm_d;
            ym_q          <= ym_d;
            prev_theta_q  <= prev_theta_d;
            prev_valid_q  <= prev_valid_d;
            run_q         <= run_d;
            dir_q         <= dir_d;
            to_cnt_q      <= to_cnt_d;
            theta_q       <= theta_d;
            theta_valid_q <= theta_valid_d;
            event_valid_q <= event_valid_d;
            event_dir_q   <= event_dir_d;
        end
    end

    assign o_theta       = theta_q;
    assign o_theta_valid = theta_valid_q;
    assign o_event_valid = event_valid_q;
    assign o_event_dir   = event_dir_q;
    assign o_run         = run_q;

endmodule

// File: tb/tb_theta_tracker.sv
// Bench for theta_tracker: directed gestures plus random vectors, checked by a scoreboard
// fed from an arithmetic reference model of sectors, runs, events and timeouts.
`timescale 1ns/1ps
module tb_theta_tracker;
    localparam int BITS    = 8;
    localparam int RUN_LEN = 4;
    localparam int MIN_MAG = 8;
    localparam int TO      = 64;

    logic            i_clk = 1'b0, i_rst_n = 1'b0, i_clear = 1'b0, i_valid = 1'b0;
    logic            i_xSign = 1'b0, i_ySign = 1'b0;
    logic [BITS-1:0] i_x = '0, i_y = '0;
    logic            o_ready, o_theta_valid, o_event_valid, o_event_dir;
    logic [3:0]      o_theta, o_run;

    theta_tracker #(
        .BITS(BITS), .RUN_LEN(RUN_LEN), .MIN_MAG(MIN_MAG), .TIMEOUT(TO)
    ) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_clear(i_clear), .i_valid(i_valid),
        .o_ready(o_ready), .i_xSign(i_xSign), .i_ySign(i_ySign), .i_x(i_x), .i_y(i_y),
        .o_theta(o_theta), .o_theta_valid(o_theta_valid), .o_event_valid(o_event_valid),
        .o_event_dir(o_event_dir), .o_run(o_run)
    );

    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    function automatic void check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endfunction

    typedef struct {
        int u;
        int th;
        int run;
        bit ev;
        bit dir;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    // Reference model state
    int m_prev = 0, m_run = 0, m_last = 0, last_u = 0;
    bit m_pv = 1'b0, m_dir = 1'b0;

    function automatic int sector(input bit xs, input bit ys, input int x, input int y);
        bit sw;
        int a, b, f;
        sw = xs ^ ys;
        a  = sw ? y : x;
        b  = sw ? x : y;
        // Boundaries at slopes 0.4, 1 and 2.5, compared exactly in integers.
        f  = int'(10 * b > 25 * a) + int'(10 * b > 10 * a) + int'(10 * b > 4 * a);
        return int'(ys) * 8 + int'(sw) * 4 + f;
    endfunction

    function automatic void model_reset();
        m_pv  = 1'b0;
        m_run = 0;
        m_dir = 1'b0;
    endfunction

    function automatic void model_apply(input bit xs, input bit ys, input int x, input int y,
                                        input int u);
        exp_t e;
        int   th, d, el;
        bit   stp;
        th = sector(xs, ys, x, y);
        if ((x > y ? x : y) < MIN_MAG) return;
        d = (th - m_prev + 16) % 16;
        if (d >= 8) d -= 16;
        stp = m_pv && d != 0 && d >= -3 && d <= 3;
        el  = u - m_last;
        if (m_run > 0 && (stp ? el > TO : el >= TO)) m_run = 0;
        if (!m_pv) begin
            m_pv  = 1'b1;
            m_run = 0;
        end else if (stp) begin
            if (m_run == 0 || m_dir == (d > 0)) m_run++;
            else m_run = 1;
            m_dir  = (d > 0);
            m_last = u;
        end else if (d != 0) begin
            m_run = 0;
        end
        m_prev = th;
        e.ev   = (m_run == RUN_LEN);
        if (e.ev) m_run = 0;
        e.u   = u;
        e.th  = th;
        e.run = m_run;
        e.dir = m_dir;
        sb.push_back(e);
    endfunction

    // Monitor: every strobe must match the oldest expected result, at the expected cycle.
    always @(negedge i_clk) begin
        if (i_rst_n && (o_theta_valid || o_event_valid)) begin
            if (sb.size() == 0) begin
                check("unexpected_strobe", int'(o_theta_valid) + 2 * int'(o_event_valid), 0);
            end else begin
                mon_e = sb.pop_front();
                check("latency", cyc, mon_e.u);
                check("theta_valid", int'(o_theta_valid), 1);
                check("theta", int'(o_theta), mon_e.th);
                check("run", int'(o_run), mon_e.run);
                check("event_valid", int'(o_event_valid), int'(mon_e.ev));
                if (mon_e.ev) check("event_dir", int'(o_event_dir), int'(mon_e.dir));
            end
        end
    end

    task automatic handshake(input bit xs, input bit ys, input int x, input int y,
                             output int h, output bit ok);
        bit rdy;
        @(posedge i_clk);
        #1;
        i_valid = 1'b1;
        i_xSign = xs;
        i_ySign = ys;
        i_x     = BITS'(x);
        i_y     = BITS'(y);
        ok      = 1'b0;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge i_clk);
            rdy = o_ready;
            @(posedge i_clk);
            ok = rdy;
        end
        #1;
        h       = cyc;
        i_valid = 1'b0;
        // Scramble the bus during CALC; the latched vector must be used.
        i_x     = BITS'($urandom);
        i_y     = BITS'($urandom);
        i_xSign = 1'($urandom);
        i_ySign = 1'($urandom);
        check("handshake", int'(ok), 1);
    endtask

    task automatic send(input bit xs, input bit ys, input int x, input int y);
        int h;
        bit ok;
        handshake(xs, ys, x, y, h, ok);
        if (ok) model_apply(xs, ys, x, y, h + 1);
        last_u = h + 1;
        @(negedge i_clk);
        check("ready_calc", int'(o_ready), 0);
        @(negedge i_clk);
        check("ready_idle", int'(o_ready), 1);
    endtask

    task automatic do_clear();
        @(posedge i_clk);
        #1;
        i_clear = 1'b1;
        @(negedge i_clk);
        check("ready_in_clear", int'(o_ready), 0);
        @(posedge i_clk);
        #1;
        i_clear = 1'b0;
        model_reset();
    endtask

    task automatic vec_for(input int s, input int sc, output bit xs, output bit ys,
                           output int x, output int y);
        int px[4];
        int py[4];
        bit sw;
        px = '{20, 20, 10, 0};
        py = '{0, 20, 20, 20};
        sw = 1'((s >> 2) & 1);
        ys = 1'((s >> 3) & 1);
        xs = sw ^ ys;
        x  = (sw ? py[s & 3] : px[s & 3]) * sc;
        y  = (sw ? px[s & 3] : py[s & 3]) * sc;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish (checks=%0d)", checks);
        $fatal(1);
    end

    initial begin
        int  h, wsec, r, g, sc, x, y;
        bit  ok, wdir, xs, ys;

        #1;
        check("rst_ready", int'(o_ready), 1);
        check("rst_theta", int'(o_theta), 0);
        check("rst_theta_valid", int'(o_theta_valid), 0);
        check("rst_event_valid", int'(o_event_valid), 0);
        check("rst_event_dir", int'(o_event_dir), 0);
        check("rst_run", int'(o_run), 0);
        repeat (2) @(posedge i_clk);
        #2;
        i_rst_n = 1'b1;

        // CCW gesture: sectors 0..4, event on the fifth sample
        send(0, 0, 20, 0);
        send(0, 0, 20, 20);
        send(0, 0, 10, 20);
        send(0, 0, 0, 20);
        send(1, 0, 5, 20);
        check("ccw_run_after_event", int'(o_run), 0);

        // CW through the 0 -> 15 wrap
        do_clear();
        send(0, 0, 10, 20);
        send(0, 0, 20, 20);
        send(0, 0, 20, 0);
        send(0, 1, 20, 5);
        send(0, 1, 20, 10);

        // Glitch then reversal
        do_clear();
        send(0, 0, 20, 0);
        send(1, 1, 20, 0);
        check("glitch_run", int'(o_run), 0);
        send(0, 0, 20, 0);
        send(0, 0, 20, 20);
        send(0, 0, 20, 0);
        check("reversal_run", int'(o_run), 1);

        // Dead zone: accepted, no strobe, prev_theta kept
        send(0, 0, 3, 2);
        send(0, 0, 20, 20);

        // Timeout: run drops exactly TO cycles after the last step
        do_clear();
        send(0, 0, 20, 0);
        send(0, 0, 20, 20);
        send(0, 0, 10, 20);
        check("to_start_cycle", cyc, last_u);
        repeat (TO - 1) @(negedge i_clk);
        check("to_run_held", int'(o_run), 2);
        @(negedge i_clk);
        check("to_run_dropped", int'(o_run), 0);

        // Clear during CALC drops the sample
        handshake(0, 0, 20, 20, h, ok);
        i_clear = 1'b1;
        @(negedge i_clk);
        check("clear_calc_ready", int'(o_ready), 0);
        @(posedge i_clk);
        #1;
        i_clear = 1'b0;
        model_reset();
        @(negedge i_clk);
        check("clear_no_strobe", int'(o_theta_valid), 0);
        check("clear_run", int'(o_run), 0);
        send(0, 0, 10, 20);
        send(0, 0, 0, 20);

        // Asynchronous reset in the middle of CALC
        handshake(1, 0, 5, 20, h, ok);
        #2;
        i_rst_n = 1'b0;
        #1;
        check("arst_theta", int'(o_theta), 0);
        check("arst_theta_valid", int'(o_theta_valid), 0);
        check("arst_event_valid", int'(o_event_valid), 0);
        check("arst_event_dir", int'(o_event_dir), 0);
        check("arst_run", int'(o_run), 0);
        check("arst_ready", int'(o_ready), 1);
        @(posedge i_clk);
        #2;
        i_rst_n = 1'b1;
        model_reset();
        @(negedge i_clk);
        check("arst_ready_release", int'(o_ready), 1);
        check("arst_no_strobe", int'(o_theta_valid), 0);

        // Random: biased sector walk, arbitrary vectors, dead-zone vectors
        wsec = 0;
        wdir = 1'b1;
        for (int n = 0; n < 200; n++) begin
            r = $urandom_range(0, 99);
            if (r < 60) begin
                if ($urandom_range(0, 9) == 0) wdir = ~wdir;
                if ($urandom_range(0, 19) == 0) g = $urandom_range(4, 12);
                else g = wdir ? $urandom_range(0, 3) : -$urandom_range(0, 3);
                wsec = (wsec + g + 16) % 16;
                sc   = $urandom_range(1, 6);
                vec_for(wsec, sc, xs, ys, x, y);
            end else if (r < 90) begin
                xs = 1'($urandom);
                ys = 1'($urandom);
                x  = $urandom_range(0, 255);
                y  = $urandom_range(0, 255);
            end else begin
                xs = 1'($urandom);
                ys = 1'($urandom);
                x  = $urandom_range(0, MIN_MAG - 1);
                y  = $urandom_range(0, MIN_MAG - 1);
            end
            send(xs, ys, x, y);
            g = $urandom_range(0, 99);
            if (g < 5) do_clear();
            else if (g < 12) repeat ($urandom_range(50, 90)) @(posedge i_clk);
            else repeat ($urandom_range(0, 2)) @(posedge i_clk);
        end

        repeat (5) @(negedge i_clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
